// File: rtl/vram_stream_arbiter_pkg.sv
// Shared types and constants for the two-source VRAM stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_stream_arbiter_pkg;

    // Grant FSM: waiting for a requester, or forwarding one packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot owner encoding, also driven straight onto the grant output.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_TO_W    = 11;

endpackage

// File: rtl/vram_stream_arbiter_if.sv
// AXI4-Stream style beat channel (valid/ready, data, last) with both ends as modports.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master.
interface vram_stream_arbiter_if
    import vram_stream_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/vram_stream_arbiter_axis_fifo2.sv
// Two-entry stream buffer; output is the head entry, count and not-full are registered.
// Latency: a beat pushed at edge t is at the output after edge t.
// Backpressure: push ignored when full; simultaneous push and pop keeps 1 beat/cycle.
module axis_fifo2
    import vram_stream_arbiter_pkg::*;
#(
    parameter int W = DEF_DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         vld_o,
    output logic         not_full_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign vld_o      = (count_q != 2'd0);
    assign not_full_o = (count_q != 2'd2);
    assign do_push    = push_i && not_full_o;
    assign do_pop     = pop_i && vld_o;
    assign pop_dat_o  = mem_q[rd_ptr_q];

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; reset clears entries so the output reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
endmodule

// File: rtl/vram_stream_arbiter.sv
// Packet-level round-robin of two pixel streams onto the VRAM write port, with stall watchdog.
// Latency: one idle arbitration cycle per packet, then a beat reaches m_* one cycle after acceptance.
// Backpressure: source tready is registered-only (buffer count, pending timeout); no ready-to-ready path.
module vram_stream_arbiter
    import vram_stream_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic                  clk,
    input  logic                  rst,
    vram_stream_arbiter_if.slave  s0,
    vram_stream_arbiter_if.slave  s1,
    vram_stream_arbiter_if.master m,
    output logic                  m_tstrb,
    output logic                  m_tkeep,
    output logic [1:0]            grant,
    output logic                  timeout_pulse
);
    localparam bit             WD_EN      = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] STALL_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [TO_W-1:0]   stall_q, stall_d;
    logic              to_pending_q, to_pending_d;

    logic              sel_vld;
    logic [DATA_W-1:0] sel_dat;
    logic              sel_last;
    logic              rdy_grant;
    logic              accept;
    logic              force_push;
    logic              release_pkt;
    logic              push;
    logic [DATA_W:0]   push_dat;
    logic [DATA_W:0]   fifo_dat;
    logic              not_full;

    // Route the owning source's beat; nothing is selected while idle.
    always_comb begin
        sel_vld  = 1'b0;
        sel_dat  = '0;
        sel_last = 1'b0;
        case (grant_q)
            GNT_S0: begin
                sel_vld  = s0.tvalid;
                sel_dat  = s0.tdata;
                sel_last = s0.tlast;
            end
            GNT_S1: begin
                sel_vld  = s1.tvalid;
                sel_dat  = s1.tdata;
                sel_last = s1.tlast;
            end
            default: ;
        endcase
    end

    // Ready depends only on registers, so downstream ready never reaches upstream ready combinationally.
    assign rdy_grant   = (state_q == BUSY) && not_full && !to_pending_q;
    assign s0.tready   = rdy_grant && (grant_q == GNT_S0);
    assign s1.tready   = rdy_grant && (grant_q == GNT_S1);
    assign accept      = sel_vld && rdy_grant;
    // A synthetic closing beat goes in as soon as the buffer has room.
    assign force_push  = to_pending_q && not_full;
    assign release_pkt = (accept && sel_last) || force_push;
    assign push        = accept || force_push;
    assign push_dat    = force_push ? {{DATA_W{1'b0}}, 1'b1} : {sel_dat, sel_last};

    assign grant         = grant_q;
    assign timeout_pulse = force_push;
    assign m_tstrb       = 1'b1;
    assign m_tkeep       = 1'b1;
    assign m.tdata       = fifo_dat[DATA_W:1];
    assign m.tlast       = fifo_dat[0];

    // Arbitration, packet ownership and stall watchdog next-state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        to_pending_d = to_pending_q;
        case (state_q)
            IDLE: begin
                stall_d      = '0;
                to_pending_d = 1'b0;
                if (s0.tvalid && (!s1.tvalid || (last_grant_q != GNT_S0))) begin
                    grant_d = GNT_S0;
                    state_d = BUSY;
                end else if (s1.tvalid) begin
                    grant_d = GNT_S1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (to_pending_q) begin
                    stall_d = '0;
                    if (not_full) begin
                        to_pending_d = 1'b0;
                    end
                end else if (accept) begin
                    stall_d = '0;
                end else if (!sel_vld && WD_EN) begin
                    if (stall_q == STALL_LAST) begin
                        to_pending_d = 1'b1;
                        stall_d      = '0;
                    end else begin
                        stall_d = stall_q + TO_W'(1);
                    end
                end
                // Ownership ends on a real or forced tlast; re-arbitrate next cycle.
                if (release_pkt) begin
                    last_grant_d = grant_q;
                    grant_d      = GNT_NONE;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; last_grant starts at source 1 so source 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_S1;
            stall_q      <= '0;
            to_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            to_pending_q <= to_pending_d;
        end
    end

    axis_fifo2 #(
        .W (DATA_W + 1)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (m.tready),
        .pop_dat_o  (fifo_dat),
        .vld_o      (m.tvalid),
        .not_full_o (not_full)
    );
endmodule
